// File: rtl/board_pkg.sv
// Shared types and constants for the board cell RAM and its access arbiter.
//   BOARD_SIZE / CELL_COUNT : 10x10 board, valid cell indices are 0..99
//   cell_t / cell_addr_t    : one cell word and one cell index
//   owner_t                 : which requester a RAM read in flight belongs to
package board_pkg;

  localparam int BOARD_SIZE = 10;
  localparam int CELL_COUNT = BOARD_SIZE * BOARD_SIZE;
  localparam int CELL_W     = 16;
  localparam int ADDR_W     = 7;

  typedef logic [CELL_W-1:0] cell_t;
  typedef logic [ADDR_W-1:0] cell_addr_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_RENDER,
    OWN_LOGIC
  } owner_t;

endpackage

// File: rtl/board_access_arbiter.sv
// Shares the single-port, synchronous-read board cell RAM between the pixel
// renderer (priority) and the game logic (bounded wait, force-granted after
// MAX_WAIT lost cycles).
//
// Ports:
//   clk, reset_n                     pixel clock, async active-low reset
//   hdata, vdata                     scan position (vdata used only with
//                                    BOARD_TEAR_FREE_EN)
//   render_req/addr -> render_gnt    renderer read request, comb grant
//   render_rvalid/rdata              renderer read return (2-cycle latency)
//   logic_req/we/addr/wdata -> gnt   game-logic read/write request
//   logic_rvalid/rdata               game-logic read return
//   ram_en/we/addr/wdata, ram_rdata  registered RAM command, RAM read data
//
// Build option: define BOARD_TEAR_FREE_EN to restrict logic writes to the
// vertical blank (vdata >= V_ACTIVE).
module board_access_arbiter
  import board_pkg::*;
#(
  parameter int VGA_WIDTH = 12,
  parameter int CELL_W    = board_pkg::CELL_W,
  parameter int ADDR_W    = board_pkg::ADDR_W,
  parameter int MAX_WAIT  = 8,
  parameter int V_ACTIVE  = 480
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [VGA_WIDTH-1:0] hdata,
  input  logic [VGA_WIDTH-1:0] vdata,
  input  logic                 render_req,
  input  logic [ADDR_W-1:0]    render_addr,
  output logic                 render_gnt,
  output logic                 render_rvalid,
  output logic [CELL_W-1:0]    render_rdata,
  input  logic                 logic_req,
  input  logic                 logic_we,
  input  logic [ADDR_W-1:0]    logic_addr,
  input  logic [CELL_W-1:0]    logic_wdata,
  output logic                 logic_gnt,
  output logic                 logic_rvalid,
  output logic [CELL_W-1:0]    logic_rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [CELL_W-1:0]    ram_wdata,
  input  logic [CELL_W-1:0]    ram_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              write_window, logic_ok, force_logic;
  logic              accept, acc_we, acc_in_range;
  logic [ADDR_W-1:0] acc_addr;
  owner_t            acc_owner;
  owner_t            owner_pipe [2:1];
  logic [2:1]        oor_pipe;
  logic [CELL_W-1:0] rd_word, render_hold, logic_hold;

`ifdef BOARD_TEAR_FREE_EN
  // Writes only land during vertical blank so a frame never shows a torn board.
  assign write_window = !logic_we || (vdata >= VGA_WIDTH'(V_ACTIVE));
  logic unused_scan;
  assign unused_scan = ^hdata;
`else
  assign write_window = 1'b1;
  logic unused_scan;
  assign unused_scan = ^{hdata, vdata};
`endif

  // A suppressed write still accumulates wait, but the force only fires
  // once the write is eligible again (logic_ok).
  assign logic_ok    = logic_req && write_window;
  assign force_logic = (wait_cnt == WAIT_W'(MAX_WAIT));
  assign render_gnt  = reset_n && render_req && !(logic_ok && force_logic);
  assign logic_gnt   = reset_n && logic_ok && (!render_req || force_logic);

  assign accept       = render_gnt || logic_gnt;
  assign acc_addr     = render_gnt ? render_addr : logic_addr;
  assign acc_we       = logic_gnt && logic_we;
  assign acc_in_range = (acc_addr < ADDR_W'(CELL_COUNT));

  always_comb begin
    acc_owner = OWN_NONE;
    if (render_gnt)                acc_owner = OWN_RENDER;
    else if (logic_gnt && !logic_we) acc_owner = OWN_LOGIC;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (!logic_req || logic_gnt) begin
      wait_cnt <= '0;
    end else if (!force_logic) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Stage 1: RAM command. Out-of-range accesses keep ram_en low but still
  // travel down the owner pipe so a read gets its (zero) answer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_en        <= 1'b0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      owner_pipe[1] <= OWN_NONE;
      oor_pipe[1]   <= 1'b0;
    end else begin
      ram_en        <= accept && acc_in_range;
      ram_we        <= acc_we && acc_in_range;
      owner_pipe[1] <= acc_owner;
      oor_pipe[1]   <= !acc_in_range;
      if (accept) ram_addr  <= acc_addr;
      if (acc_we) ram_wdata <= logic_wdata;
    end
  end

  // Stage 2: tag lines up with ram_rdata, which the RAM presents one cycle
  // after the command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_pipe[2] <= OWN_NONE;
      oor_pipe[2]   <= 1'b0;
    end else begin
      owner_pipe[2] <= owner_pipe[1];
      oor_pipe[2]   <= oor_pipe[1];
    end
  end

  assign rd_word       = oor_pipe[2] ? '0 : ram_rdata;
  assign render_rvalid = (owner_pipe[2] == OWN_RENDER);
  assign logic_rvalid  = (owner_pipe[2] == OWN_LOGIC);

  // Return data passes straight through in the valid cycle; otherwise each
  // side shows the last word it was handed.
  assign render_rdata = render_rvalid ? rd_word : render_hold;
  assign logic_rdata  = logic_rvalid  ? rd_word : logic_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      render_hold <= '0;
      logic_hold  <= '0;
    end else begin
      if (render_rvalid) render_hold <= rd_word;
      if (logic_rvalid)  logic_hold  <= rd_word;
    end
  end

endmodule

// File: tb/tb_board_access_arbiter.sv
// Self-checking bench for board_access_arbiter: a behavioural RAM answers
// the DUT's commands, grants push expected read data into per-requester
// queues, and returned data is popped and compared (value and latency).
module tb_board_access_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] hdata = '0, vdata = 12'd480;
  logic        render_req = 1'b0, logic_req = 1'b0, logic_we = 1'b0;
  logic [6:0]  render_addr = '0, logic_addr = '0;
  logic [15:0] logic_wdata = '0;
  logic        render_gnt, render_rvalid, logic_gnt, logic_rvalid;
  logic [15:0] render_rdata, logic_rdata;
  logic        ram_en, ram_we;
  logic [6:0]  ram_addr;
  logic [15:0] ram_wdata, ram_rdata;

  board_access_arbiter dut (
    .clk(clk), .reset_n(reset_n), .hdata(hdata), .vdata(vdata),
    .render_req(render_req), .render_addr(render_addr), .render_gnt(render_gnt),
    .render_rvalid(render_rvalid), .render_rdata(render_rdata),
    .logic_req(logic_req), .logic_we(logic_we), .logic_addr(logic_addr),
    .logic_wdata(logic_wdata), .logic_gnt(logic_gnt),
    .logic_rvalid(logic_rvalid), .logic_rdata(logic_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous-read RAM; unwritten cells read a per-address pattern.
  bit [15:0] mem [128];
  bit        mem_wr [128];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr]    <= ram_wdata;
        mem_wr[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= mem_wr[ram_addr] ? mem[ram_addr] : (16'hC000 | {9'd0, ram_addr});
      end
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Bench-side shadow of the board contents, updated when a write is granted.
  bit [15:0] shadow [128];
  bit        sh_wr [128];

  function automatic logic [15:0] exp_rd(input logic [6:0] a);
    if (a >= 7'd100) return 16'h0000;
    return sh_wr[a] ? shadow[a] : (16'hC000 | {9'd0, a});
  endfunction

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb_r[$], sb_l[$];

  always @(negedge clk) begin
    exp_t e;
    if (render_rvalid) begin
      if (sb_r.size() == 0) chk("render_unexpected_rvalid", 1, 0);
      else begin
        e = sb_r.pop_front();
        chk("render_rdata", render_rdata, e.data);
        chk("render_latency", cyc, e.due);
      end
    end
    if (logic_rvalid) begin
      if (sb_l.size() == 0) chk("logic_unexpected_rvalid", 1, 0);
      else begin
        e = sb_l.pop_front();
        chk("logic_rdata", logic_rdata, e.data);
        chk("logic_latency", cyc, e.due);
      end
    end
    if (render_req && render_gnt)
      sb_r.push_back('{data: exp_rd(render_addr), due: cyc + 2});
    if (logic_req && logic_gnt) begin
      if (logic_we) begin
        if (logic_addr < 7'd100) begin
          shadow[logic_addr] = logic_wdata;
          sh_wr[logic_addr]  = 1'b1;
        end
      end else begin
        sb_l.push_back('{data: exp_rd(logic_addr), due: cyc + 2});
      end
    end
  end

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      render_req = 1'b0;
      logic_req  = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {render_gnt, render_rvalid, render_rdata, logic_gnt,
        logic_rvalid, logic_rdata, ram_en, ram_we, ram_addr, ram_wdata}, 0);
    reset_n = 1'b1;

    // 1: renderer-only reads 0, 5, 99 back to back
    drive(); render_req = 1'b1; render_addr = 7'd0;
    @(negedge clk); chk("t1_gnt0", render_gnt, 1);
    drive(); render_addr = 7'd5;
    @(negedge clk); chk("t1_gnt5", render_gnt, 1);
    chk("t1_ram_en", ram_en, 1); chk("t1_addr0", ram_addr, 0);
    drive(); render_addr = 7'd99;
    @(negedge clk); chk("t1_gnt99", render_gnt, 1); chk("t1_addr5", ram_addr, 5);
    drive(); render_req = 1'b0;
    @(negedge clk); chk("t1_addr99", ram_addr, 99); chk("t1_we", ram_we, 0);
    idle(3);

    // 2: both requesting; logic wins on the 9th cycle
    for (int i = 0; i < 8; i++) begin
      drive();
      render_req = 1'b1; render_addr = 7'(10 + i);
      logic_req = 1'b1; logic_we = 1'b0; logic_addr = 7'd7;
      @(negedge clk);
      chk("t2_render_gnt", render_gnt, 1);
      chk("t2_logic_wait", logic_gnt, 0);
    end
    drive(); render_addr = 7'd20;
    @(negedge clk); chk("t2_forced_logic", logic_gnt, 1); chk("t2_render_held", render_gnt, 0);
    drive(); logic_addr = 7'd8;
    @(negedge clk); chk("t2_render_resume", render_gnt, 1); chk("t2_wait_cleared", logic_gnt, 0);
    idle(3);

    // 3: write 42 = BEEF then read it back
    drive(); logic_req = 1'b1; logic_we = 1'b1; logic_addr = 7'd42; logic_wdata = 16'hBEEF;
    @(negedge clk); chk("t3_wr_gnt", logic_gnt, 1);
    drive(); logic_we = 1'b0;
    @(negedge clk); chk("t3_rd_gnt", logic_gnt, 1);
    chk("t3_ram_cmd", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 1'b1, 7'd42, 16'hBEEF});
    drive(); logic_req = 1'b0;
    @(negedge clk); chk("t3_rd_cmd", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 7'd42});
    drive();
    @(negedge clk); chk("t3_idle_hold", {ram_en, ram_addr, ram_wdata}, {1'b0, 7'd42, 16'hBEEF});
    idle(2);

    // 4: out-of-range reads return zero without enabling the RAM
    drive(); render_req = 1'b1; render_addr = 7'd127;
    logic_req = 1'b1; logic_we = 1'b0; logic_addr = 7'd100;
    @(negedge clk); chk("t4_render_gnt", render_gnt, 1);
    drive(); render_req = 1'b0;
    @(negedge clk); chk("t4_logic_gnt", logic_gnt, 1); chk("t4_en_r", ram_en, 0);
    drive(); logic_req = 1'b0;
    @(negedge clk); chk("t4_en_l", ram_en, 0);
    idle(3);

    // 5: reset one cycle after a renderer grant drops the read
    drive(); render_req = 1'b1; render_addr = 7'd3;
    @(negedge clk); chk("t5_gnt", render_gnt, 1);
    drive(); render_req = 1'b0;
    @(negedge clk); #2;
    reset_n = 1'b0;
    sb_r.delete();
    #1;
    chk("t5_async_zero", {render_gnt, render_rvalid, render_rdata, logic_gnt,
        logic_rvalid, logic_rdata, ram_en, ram_we, ram_addr, ram_wdata}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("t5_no_rvalid", render_rvalid, 0);
    end
    reset_n = 1'b1;
    idle(4);

    // 6: write timing relative to the vertical blank
`ifdef BOARD_TEAR_FREE_EN
    for (int i = 0; i < 12; i++) begin
      drive(); vdata = 12'd100;
      render_req = 1'b1; render_addr = 7'd1;
      logic_req = 1'b1; logic_we = 1'b1; logic_addr = 7'd10; logic_wdata = 16'h1234;
      @(negedge clk);
      chk("t6_wr_blocked", logic_gnt, 0);
      chk("t6_render_ok", render_gnt, 1);
    end
    drive(); vdata = 12'd480;
    @(negedge clk); chk("t6_wr_in_blank", logic_gnt, 1); chk("t6_render_held", render_gnt, 0);
`else
    drive(); vdata = 12'd100;
    logic_req = 1'b1; logic_we = 1'b1; logic_addr = 7'd10; logic_wdata = 16'h1234;
    @(negedge clk); chk("t6_wr_any_row", logic_gnt, 1);
`endif
    drive(); render_req = 1'b0; logic_we = 1'b0; vdata = 12'd480;
    @(negedge clk); chk("t6_rd_gnt", logic_gnt, 1);
    idle(5);

    chk("render_queue_drained", sb_r.size(), 0);
    chk("logic_queue_drained", sb_l.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/board_access_arbiter.md
Name: board_access_arbiter

Overview:
- Shares the single-port, synchronous-read board cell RAM (10x10 cells) between two requesters:
  - the pixel renderer, which prefetches cell contents ahead of the grid painter;
  - the game logic, which reads and writes cells.
- Renderer has priority; a bounded-wait counter guarantees game-logic progress.
- Sits between the renderer/game FSM and the board RAM, clocked in the pixel domain.

Parameters:
- VGA_WIDTH, 12, width of the scan coordinates hdata/vdata.
- CELL_W, 16, width of one board cell word.
- ADDR_W, 7, cell index width; valid indices are 0..99.
- MAX_WAIT, 8, cycles a pending logic request may lose before it is force-granted.
- V_ACTIVE, 480, first vdata value treated as vertical blank.

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- hdata  in  VGA_WIDTH  current scan column (observational)
- vdata  in  VGA_WIDTH  current scan row
- render_req  in  1  renderer read request; held until granted
- render_addr  in  ADDR_W  renderer cell index
- render_gnt  out  1  combinational; request accepted this cycle
- render_rvalid  out  1  renderer read data valid
- render_rdata  out  CELL_W  renderer read data
- logic_req  in  1  logic request; held with we/addr/wdata stable until granted
- logic_we  in  1  1 = write, 0 = read
- logic_addr  in  ADDR_W  logic cell index
- logic_wdata  in  CELL_W  write data
- logic_gnt  out  1  combinational; request accepted this cycle
- logic_rvalid  out  1  logic read data valid
- logic_rdata  out  CELL_W  logic read data
- ram_en  out  1  registered RAM enable
- ram_we  out  1  registered RAM write enable
- ram_addr  out  ADDR_W  registered RAM address
- ram_wdata  out  CELL_W  registered RAM write data
- ram_rdata  in  CELL_W  RAM read data, valid one cycle after a read command

Behaviour:
- Reset:
  - All outputs are 0 and wait_cnt is 0.
  - Pipeline valid bits are cleared, so reads in flight when reset asserts are dropped and no rvalid is produced.
- Acceptance:
  - At most one access is accepted per cycle, on an edge where req && gnt.
  - Requesters must hold their fields stable while req is high and gnt is low.
- Arbitration in cycle N:
  - Only one requester asserting: that requester is granted.
  - Both asserting and wait_cnt < MAX_WAIT: the renderer is granted.
  - Both asserting and wait_cnt == MAX_WAIT: logic is granted and render_gnt stays low.
- wait_cnt:
  - Increments when logic_req && !logic_gnt.
  - Saturates at MAX_WAIT.
  - Clears to 0 on a logic grant, or whenever logic_req is low.
- Pipeline:
  - An access accepted in cycle N drives ram_en/we/addr/wdata from registers in cycle N+1.
  - For a read, the owner's rvalid is high in cycle N+2 with rdata = ram_rdata. Read latency is therefore exactly 2 cycles.
  - A 2-deep owner tag pipeline routes read data, so back-to-back reads by alternating requesters return in order.
  - The rdata of the non-owner holds its last value.
  - Writes produce no rvalid.
- Out-of-range index (addr >= 100):
  - The access is accepted normally, but ram_en stays 0 in N+1.
  - A read returns rvalid in N+2 with rdata = 0.
  - A write is silently dropped.
- Idle cycles: ram_en = 0; ram_addr/ram_wdata hold their previous values.

Optional Feature:
- BOARD_TEAR_FREE_EN defined:
  - A logic write is grantable only while vdata >= V_ACTIVE; outside that window logic_gnt is forced low for writes.
  - A suppressed write increments wait_cnt but is never force-granted outside the window. The force-grant applies on the first eligible cycle.
  - Logic reads are unaffected.
- Undefined: writes follow the normal arbitration at any scan position, and vdata is unused.

Decomposition:
- board_pkg holds:
  - constants BOARD_SIZE = 10 and CELL_COUNT = 100;
  - typedefs cell_t (logic [CELL_W-1:0]) and cell_addr_t (logic [ADDR_W-1:0]);
  - enum owner_t {OWN_NONE, OWN_RENDER, OWN_LOGIC}.
- A single module with no sub-module. The grant logic, wait counter and 2-stage owner/valid pipeline are small enough to keep inline.

Test Plan:
1. Renderer-only reads of addr 0, 5, 99 on consecutive cycles: gnt each cycle; ram_addr is 0, 5, 99 in cycles 1..3; render_rvalid in cycles 2..4 with matching data.
2. Both requesting continuously with MAX_WAIT = 8: renderer is granted 8 cycles, logic is granted on the 9th, then wait_cnt returns to 0 and the renderer resumes.
3. Logic write addr 42 = 16'hBEEF, then logic read addr 42: ram_we pulses once; the read returns 16'hBEEF two cycles after its grant; no rvalid for the write.
4. Logic read addr 100 and renderer read addr 127: ram_en stays 0; each rvalid arrives after 2 cycles with rdata = 0.
5. Assert reset_n low one cycle after a renderer grant: no render_rvalid is produced; all outputs are 0 asynchronously.
6. With BOARD_TEAR_FREE_EN, a logic write is requested at vdata = 100: no grant until vdata = 480, then granted in that cycle even with a concurrent render_req.
